// File: rtl/digit_glyph_writer.sv
// Copies two BCD digit glyphs from the glyph ROM into the tens/ones display-RAM regions during vblank.
// Optional build macro SKIP_UNCHANGED_EN: skip regions whose digit matches the last completed copy.
module digit_glyph_writer #(
  parameter int GLYPH_W    = 70,
  parameter int GLYPH_H    = 140,
  parameter int GLYPH_SIZE = GLYPH_W * GLYPH_H,
  parameter int PIX_W      = 1
) (
  input  logic             CLOCK_25,
  input  logic             iRST,
  input  logic             iStart,
  input  logic [3:0]       iTens,
  input  logic [3:0]       iOnes,
  input  logic             iVblank,
  output logic             rom_rdEN,
  output logic [16:0]      rom_addr,
  input  logic [PIX_W-1:0] rom_data,
  output logic             wrEN,
  output logic [16:0]      wr_addr,
  output logic [PIX_W-1:0] wr_data,
  output logic             region_sel,
  output logic             oBusy,
  output logic             oDone
);

  // state     | meaning
  // IDLE      | waiting for iStart
  // WAIT_SYNC | digits latched, waiting for vertical blanking
  // COPY      | one ROM read per cycle, region 0 then region 1
  // FLUSH     | last pipelined write drains
  // DONE      | oDone pulse, history update
  typedef enum logic [2:0] {S_IDLE, S_WAIT_SYNC, S_COPY, S_FLUSH, S_DONE} state_t;

  localparam int CNT_W = $clog2(GLYPH_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GLYPH_SIZE - 1);

  state_t           state_q, state_d;
  logic [3:0]       tens_q, tens_d, ones_q, ones_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_region_q, rd_region_d;
  logic             skip1_q, skip1_d;
  logic             wr_en_q, wr_en_d;
  logic [CNT_W-1:0] wr_addr_q, wr_addr_d;
  logic             wr_region_q, wr_region_d;
  logic             wr_blank_q, wr_blank_d;

  logic       skip_t, skip_o;
  logic [3:0] digit_rd;
  logic       digit_ok, in_copy;

`ifdef SKIP_UNCHANGED_EN
  logic [3:0] last_tens_q, last_tens_d, last_ones_q, last_ones_d;
  assign skip_t = (iTens == last_tens_q);
  assign skip_o = (iOnes == last_ones_q);
`else
  assign skip_t = 1'b0;
  assign skip_o = 1'b0;
`endif

  assign digit_rd = rd_region_q ? ones_q : tens_q;
  assign digit_ok = (digit_rd <= 4'd9);
  assign in_copy  = (state_q == S_COPY);

  // Blank digits keep the write timing but never touch the ROM.
  assign rom_rdEN   = in_copy && digit_ok;
  assign rom_addr   = rom_rdEN ? (17'(digit_rd) * 17'(GLYPH_SIZE) + 17'(cnt_q)) : 17'd0;
  assign wrEN       = wr_en_q;
  assign wr_addr    = 17'(wr_addr_q);
  assign region_sel = wr_region_q;
  assign wr_data    = (wr_en_q && !wr_blank_q) ? rom_data : '0;
  assign oBusy      = (state_q == S_WAIT_SYNC) || in_copy || (state_q == S_FLUSH);
  assign oDone      = (state_q == S_DONE);

  always_comb begin
    state_d     = state_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    cnt_d       = cnt_q;
    rd_region_d = rd_region_q;
    skip1_d     = skip1_q;
    wr_en_d     = in_copy;
    wr_addr_d   = wr_addr_q;
    wr_region_d = wr_region_q;
    wr_blank_d  = wr_blank_q;
`ifdef SKIP_UNCHANGED_EN
    last_tens_d = last_tens_q;
    last_ones_d = last_ones_q;
`endif
    if (in_copy) begin
      wr_addr_d   = cnt_q;
      wr_region_d = rd_region_q;
      wr_blank_d  = !digit_ok;
    end
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          tens_d      = iTens;
          ones_d      = iOnes;
          cnt_d       = '0;
          rd_region_d = skip_t;
          skip1_d     = skip_o;
          state_d     = (skip_t && skip_o) ? S_DONE : S_WAIT_SYNC;
        end
      end
      S_WAIT_SYNC: begin
        if (iVblank) state_d = S_COPY;
      end
      S_COPY: begin
        if (cnt_q == CNT_LAST) begin
          if (rd_region_q || skip1_q) begin
            state_d = S_FLUSH;
          end else begin
            cnt_d       = '0;
            rd_region_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FLUSH: state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
`ifdef SKIP_UNCHANGED_EN
        last_tens_d = tens_q;
        last_ones_d = ones_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_25) begin
    if (iRST) begin
      state_q     <= S_IDLE;
      tens_q      <= '0;
      ones_q      <= '0;
      cnt_q       <= '0;
      rd_region_q <= 1'b0;
      skip1_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_region_q <= 1'b0;
      wr_blank_q  <= 1'b0;
`ifdef SKIP_UNCHANGED_EN
      last_tens_q <= 4'hF;
      last_ones_q <= 4'hF;
`endif
    end else begin
      state_q     <= state_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      cnt_q       <= cnt_d;
      rd_region_q <= rd_region_d;
      skip1_q     <= skip1_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_region_q <= wr_region_d;
      wr_blank_q  <= wr_blank_d;
`ifdef SKIP_UNCHANGED_EN
      last_tens_q <= last_tens_d;
      last_ones_q <= last_ones_d;
`endif
    end
  end

endmodule

// File: tb/tb_digit_glyph_writer.sv
// Directed bench for digit_glyph_writer with a behavioural one-cycle-latency glyph ROM.
module tb_digit_glyph_writer;

  localparam int SZ = 9800;

  logic        CLOCK_25 = 1'b0;
  logic        iRST = 1'b1;
  logic        iStart = 1'b0;
  logic [3:0]  iTens = 4'd0;
  logic [3:0]  iOnes = 4'd0;
  logic        iVblank = 1'b0;
  logic        rom_rdEN;
  logic [16:0] rom_addr;
  logic [0:0]  rom_data = 1'b0;
  logic        wrEN;
  logic [16:0] wr_addr;
  logic [0:0]  wr_data;
  logic        region_sel;
  logic        oBusy;
  logic        oDone;

  int tests = 0;
  int fails = 0;

  digit_glyph_writer dut (
    .CLOCK_25  (CLOCK_25),
    .iRST      (iRST),
    .iStart    (iStart),
    .iTens     (iTens),
    .iOnes     (iOnes),
    .iVblank   (iVblank),
    .rom_rdEN  (rom_rdEN),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .wrEN      (wrEN),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .region_sel(region_sel),
    .oBusy     (oBusy),
    .oDone     (oDone)
  );

  always #20 CLOCK_25 = ~CLOCK_25;

  function automatic logic rom_fn(input logic [16:0] a);
    return a[0] ^ a[2] ^ a[5];
  endfunction

  // Unread cycles return 1 so a blank region that leaks ROM data is visible.
  always @(posedge CLOCK_25) rom_data <= rom_rdEN ? rom_fn(rom_addr) : 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_25);
    #1;
  endtask

  // Issues a start and checks every output, every cycle, until one idle cycle after oDone.
  task automatic run_copy(input logic [3:0] t, input logic [3:0] o, input bit wr0, input bit wr1,
                          input int pre_wait, input int poke_at, input int abort_at);
    int rl[2];
    int nreg, ncopy, c0, c, w, r, dig;
    bit exp_rd, exp_wr;
    nreg = 0;
    if (wr0) begin rl[nreg] = 0; nreg++; end
    if (wr1) begin rl[nreg] = 1; nreg++; end
    ncopy = nreg * SZ;
    iTens = t; iOnes = o; iStart = 1'b1; iVblank = (pre_wait == 0);
    if (nreg == 0) begin
      step();
      iStart = 1'b0;
      chk("skip_done", oDone, 1);
      chk("skip_busy", oBusy, 0);
      chk("skip_wr", wrEN, 0);
      chk("skip_rd", rom_rdEN, 0);
      step();
      chk("skip_done_clr", oDone, 0);
      chk("skip_wr_after", wrEN, 0);
      return;
    end
    c0 = pre_wait + 1;
    for (int j = 0; j <= c0 + ncopy + 2; j++) begin
      step();
      iStart = 1'b0;
      c = j - c0;
      exp_rd = 1'b0;
      if (c >= 0 && c < ncopy) begin
        r = rl[c / SZ];
        dig = (r == 1) ? int'(o) : int'(t);
        exp_rd = (dig <= 9);
        if (exp_rd) chk("rom_addr", rom_addr, dig * SZ + (c % SZ));
      end
      chk("rom_rdEN", rom_rdEN, exp_rd);
      w = j - c0 - 1;
      exp_wr = (w >= 0 && w < ncopy);
      chk("wrEN", wrEN, exp_wr);
      if (exp_wr) begin
        r = rl[w / SZ];
        dig = (r == 1) ? int'(o) : int'(t);
        chk("region_sel", region_sel, r);
        chk("wr_addr", wr_addr, w % SZ);
        chk("wr_data", wr_data, (dig <= 9) ? rom_fn(17'(dig * SZ + (w % SZ))) : 1'b0);
      end
      chk("oBusy", oBusy, j < c0 + ncopy + 1);
      chk("oDone", oDone, j == c0 + ncopy + 1);
      if (pre_wait > 0 && j == pre_wait) iVblank = 1'b1;
      if (j == c0 + 50) iVblank = 1'b0;
      if (j == poke_at) begin
        iStart = 1'b1; iTens = 4'd1; iOnes = 4'd1;
      end
      if (j == abort_at) begin
        iRST = 1'b1;
        step();
        chk("abort_wrEN", wrEN, 0);
        chk("abort_busy", oBusy, 0);
        chk("abort_rd", rom_rdEN, 0);
        chk("abort_done", oDone, 0);
        iRST = 1'b0;
        return;
      end
    end
  endtask

  initial begin
    repeat (3) step();
    chk("rst_rdEN", rom_rdEN, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_wrEN", wrEN, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_region", region_sel, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oDone, 0);
    iRST = 1'b0;
    iVblank = 1'b1;
    step();
    chk("idle_busy", oBusy, 0);
    chk("idle_rd", rom_rdEN, 0);

    // tens=3, ones=7 with vblank already high
    run_copy(4'd3, 4'd7, 1'b1, 1'b1, 0, -1, -1);
    // wait 500 cycles for vblank, plus an ignored request at region 0 cnt 100
    run_copy(4'd8, 4'd2, 1'b1, 1'b1, 500, 501 + 100, -1);
    step();
    chk("post_poke_busy", oBusy, 0);
    chk("post_poke_done", oDone, 0);
    // reset in the middle of region 1
    run_copy(4'd4, 4'd5, 1'b1, 1'b1, 0, -1, 1 + SZ + 50);
    // blank tens digit after the reset; full copy
    run_copy(4'hC, 4'd0, 1'b1, 1'b1, 0, -1, -1);
`ifdef SKIP_UNCHANGED_EN
    run_copy(4'hC, 4'd6, 1'b0, 1'b1, 0, -1, -1);
    run_copy(4'hC, 4'd6, 1'b0, 1'b0, 0, -1, -1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
